// File: rtl/multi_servo_pwm.sv
// Multi-channel hobby-servo PWM generator.
// One shared frame counter drives N_CH pulse comparators. Requested widths are clamped and
// held per channel; the generated width only changes at the frame boundary so every pulse
// is whole. Define SERVO_SLEW_EN to rate-limit width changes to SLEW_STEP ticks per frame.
module multi_servo_pwm #(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned FRAME_US   = 20000,
    parameter int unsigned PW_MIN     = 1000,
    parameter int unsigned PW_MAX     = 2000,
    parameter int unsigned PW_NEUTRAL = 1500,
    parameter int unsigned SLEW_STEP  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11*N_CH-1:0]   pw_in,
    input  logic [N_CH-1:0]      pw_valid,
    input  logic [N_CH-1:0]      inhibit,
    output logic [N_CH-1:0]      pwm_out,
    output logic [11*N_CH-1:0]   pw_active,
    output logic                 frame_sync
);

    localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast  = TickW'(CLK_DIV - 1);
    localparam logic [14:0]      FrameLast = 15'(FRAME_US - 1);
    localparam logic [14:0]      PwMin15   = 15'(PW_MIN);
    localparam logic [14:0]      PwMax15   = 15'(PW_MAX);
    localparam logic [10:0]      PwMin     = 11'(PW_MIN);
    localparam logic [10:0]      PwMax     = 11'(PW_MAX);
    localparam logic [10:0]      PwNeutral = 11'(PW_NEUTRAL);

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [14:0]      frame_cnt_q, frame_cnt_d;
    logic             frame_sync_q, frame_sync_d;
    logic [N_CH-1:0]  pwm_out_q, pwm_out_d;
    logic [10:0]      target_q [N_CH];
    logic [10:0]      target_d [N_CH];
    logic [10:0]      active_q [N_CH];
    logic [10:0]      active_d [N_CH];
    logic [10:0]      eff_target [N_CH];
    logic             tick;
    logic             frame_bound;

    // Clamp a raw request into the legal pulse window; widened so no compare can wrap.
    function automatic logic [10:0] clamp_pw(input logic [10:0] raw);
        logic [14:0] raw15;
        raw15 = {4'b0, raw};
        if (raw15 < PwMin15) begin
            return PwMin;
        end else if (raw15 > PwMax15) begin
            return PwMax;
        end
        return raw;
    endfunction

`ifdef SERVO_SLEW_EN
    // Step toward tgt by at most SLEW_STEP, landing exactly when close enough.
    function automatic logic [10:0] slew_to(input logic [10:0] cur, input logic [10:0] tgt);
        logic [14:0] c15;
        logic [14:0] t15;
        logic [14:0] step15;
        c15    = {4'b0, cur};
        t15    = {4'b0, tgt};
        step15 = 15'(SLEW_STEP);
        if (t15 >= c15) begin
            if (t15 - c15 <= step15) begin
                return tgt;
            end
            return 11'(c15 + step15);
        end
        if (c15 - t15 <= step15) begin
            return tgt;
        end
        return 11'(c15 - step15);
    endfunction
`endif

    // Tick prescaler and frame counter; the frame wrap edge is the only update point.
    always_comb begin
        tick         = (tick_cnt_q == TickLast);
        frame_bound  = tick && (frame_cnt_q == FrameLast);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TickW'(1);
        frame_cnt_d  = frame_cnt_q;
        if (tick) begin
            frame_cnt_d = frame_bound ? 15'd0 : frame_cnt_q + 15'd1;
        end
        frame_sync_d = frame_bound;
    end

    // Per-channel target capture, frame-boundary width update and pulse compare.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            target_d[i]   = target_q[i];
            eff_target[i] = inhibit[i] ? PwNeutral : target_q[i];
            active_d[i]   = active_q[i];
            pwm_out_d[i]  = (frame_cnt_q < {4'b0, active_q[i]});
            if (pw_valid[i]) begin
                target_d[i] = clamp_pw(pw_in[11*i +: 11]);
            end
            // Boundary uses the pre-edge target, so a same-edge request waits a frame.
            if (frame_bound) begin
`ifdef SERVO_SLEW_EN
                active_d[i] = slew_to(active_q[i], eff_target[i]);
`else
                active_d[i] = eff_target[i];
`endif
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            frame_sync_q <= 1'b0;
            pwm_out_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= PwNeutral;
                active_q[i] <= PwNeutral;
            end
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_sync_q <= frame_sync_d;
            pwm_out_q    <= pwm_out_d;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out    = pwm_out_q;
    assign frame_sync = frame_sync_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_act
        assign pw_active[11*g +: 11] = active_q[g];
    end

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Self-checking bench for multi_servo_pwm with a per-frame scoreboard of expected widths.
module tb_multi_servo_pwm;

    localparam int N_CH  = 3;
    localparam int DIV   = 2;
    localparam int FRAME = 100;
    localparam int PMIN  = 10;
    localparam int PMAX  = 20;
    localparam int NEU   = 15;
    localparam int STEP  = 2;
    localparam int FRAME_CLK = DIV * FRAME;

    logic                clk;
    logic                rst;
    logic [11*N_CH-1:0]  pw_in;
    logic [N_CH-1:0]     pw_valid;
    logic [N_CH-1:0]     inhibit;
    logic [N_CH-1:0]     pwm_out;
    logic [11*N_CH-1:0]  pw_active;
    logic                frame_sync;

    int n_checks = 0;
    int n_errors = 0;
    int m_target [N_CH];
    int m_active [N_CH];
    logic [11*N_CH-1:0] sb [$];

    multi_servo_pwm #(
        .N_CH      (N_CH),
        .CLK_DIV   (DIV),
        .FRAME_US  (FRAME),
        .PW_MIN    (PMIN),
        .PW_MAX    (PMAX),
        .PW_NEUTRAL(NEU),
        .SLEW_STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pw_in     (pw_in),
        .pw_valid  (pw_valid),
        .inhibit   (inhibit),
        .pwm_out   (pwm_out),
        .pw_active (pw_active),
        .frame_sync(frame_sync)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    function automatic int next_act(input int cur, input int eff);
`ifdef SERVO_SLEW_EN
        if (eff > cur + STEP) return cur + STEP;
        if (eff < cur - STEP) return cur - STEP;
        return eff;
`else
        if (cur == eff) return cur;
        return eff;
`endif
    endfunction

    function automatic logic [11*N_CH-1:0] pack_all(input int v0, input int v1, input int v2);
        logic [11*N_CH-1:0] r;
        r = {11'(v2), 11'(v1), 11'(v0)};
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_target[i] = NEU;
            m_active[i] = NEU;
        end
        sb.delete();
    endfunction

    // Present a request; run_frame drops the strobe after the first edge.
    task automatic set_pw(input int ch, input int val);
        pw_in[11*ch +: 11] = 11'(val);
        pw_valid[ch]       = 1'b1;
        m_target[ch]       = clamp(val);
    endtask

    // Count edges until frame_sync is seen (bounded).
    task automatic wait_sync(output int n);
        n = 0;
        while (n < 2 * FRAME_CLK) begin
            @(posedge clk);
            #1;
            n++;
            if (pw_valid != '0) pw_valid = '0;
            if (frame_sync) return;
        end
    endtask

    // Run one frame starting just after a frame_sync sample; optionally fire a request
    // timed to land on the boundary edge itself.
    task automatic run_frame(input bit coll, input int cch, input int cval);
        int exp_next [N_CH];
        int hi [N_CH];
        int cyc;
        bit seen;
        logic [11*N_CH-1:0] e;
        for (int i = 0; i < N_CH; i++) begin
            exp_next[i] = next_act(m_active[i], inhibit[i] ? NEU : m_target[i]);
            hi[i] = 0;
        end
        sb.push_back(pack_all(exp_next[0], exp_next[1], exp_next[2]));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 2 * FRAME_CLK) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < N_CH; i++) if (pwm_out[i]) hi[i]++;
            if (frame_sync) begin
                seen = 1'b1;
            end else begin
                if (cyc == 1) pw_valid = '0;
                if (coll && cyc == FRAME_CLK - 1) begin
                    pw_in[11*cch +: 11] = 11'(cval);
                    pw_valid[cch]       = 1'b1;
                end
            end
        end
        pw_valid = '0;
        check_eq("frame_len", 64'(cyc), 64'(FRAME_CLK));
        for (int i = 0; i < N_CH; i++) check_eq("high_time", 64'(hi[i]), 64'(DIV * m_active[i]));
        if (coll) m_target[cch] = clamp(cval);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("pw_active", 64'(pw_active), 64'(e));
        end
        for (int i = 0; i < N_CH; i++) m_active[i] = exp_next[i];
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        pw_in    = '0;
        pw_valid = '0;
        inhibit  = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pw_active", 64'(pw_active), 64'(pack_all(NEU, NEU, NEU)));
        check_eq("rst_pwm_out", 64'(pwm_out), 64'(0));
        check_eq("rst_frame_sync", 64'(frame_sync), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_pwm_high", 64'(pwm_out), 64'(3'b111));
        wait_sync(n);
        check_eq("first_frame_len", 64'(n), 64'(FRAME_CLK - 1));
        run_frame(1'b0, 0, 0);

        // Clamp high then low on ch0
        set_pw(0, 2047);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);
        set_pw(0, 3);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);

        // Slew / direct step on ch1
        set_pw(1, 20);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);

        // Inhibit on ch2 holds neutral, release resumes the stored target
        set_pw(2, 20);
        run_frame(1'b0, 0, 0);
        inhibit[2] = 1'b1;
        run_frame(1'b0, 0, 0);
        inhibit[2] = 1'b0;
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);

        // Request arriving on the boundary edge applies one frame late
        run_frame(1'b1, 0, 12);
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 0, 0);

        // Mid-frame reset at frame_cnt = 40, with a pending target change
        set_pw(1, 10);
        for (int k = 0; k < 2 * 40; k++) begin
            @(posedge clk);
            #1;
            pw_valid = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_pw_active", 64'(pw_active), 64'(pack_all(NEU, NEU, NEU)));
        check_eq("mid_rst_pwm_out", 64'(pwm_out), 64'(0));
        check_eq("mid_rst_frame_sync", 64'(frame_sync), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_pwm_high", 64'(pwm_out), 64'(3'b111));
        wait_sync(n);
        check_eq("mid_rst_frame_len", 64'(n), 64'(FRAME_CLK - 1));
        model_reset();
        run_frame(1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
